i2c_txn_sched: RTL

//  Two-requester I2C single-byte transaction scheduler. Arbitrates between two

---
 rtl/i2c_txn_sched.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_txn_sched.sv
// -----------------------------------------------------------------------------
// i2c_txn_sched
//   Two-requester I2C single-byte transaction scheduler. A round-robin arbiter
//   picks one of two local clients. The chosen client's request is then run as
//   START / ADDR(7b + rw) / ACK / DATA / ACK / STOP on an open-drain bus.
//   Each bit lasts 4*DIVIDER clk and is split into four quarter phases.
//   SCL is pulled low in phases 0-1 and released in phases 2-3. Slave bits are
//   sampled on the last clk of phase 2.
//
//   Build option: define I2C_SCHED_STRETCH_EN to honour slave clock
//   stretching. When it is defined, the quarter counter holds while SCL is
//   released but still reads low. When it is undefined, scl_in is ignored.
//
// Parameters
//   DIVIDER  clk cycles per quarter bit period
//   CBITS    quarter counter width; must hold 4*DIVIDER-1
//
// Ports
//   clk      in   system clock (posedge)
//   rst      in   asynchronous active-high reset
//   req      in   [1:0]  level request per client
//   addr     in   [13:0] {addr1, addr0}, 7-bit slave address per client
//   rw       in   [1:0]  1 = read, 0 = write, per client
//   wdata    in   [15:0] {wdata1, wdata0}, write byte per client
//   gnt      out  [1:0]  one-cycle pulse when a request is accepted
//   done     out  [1:0]  one-cycle pulse when a transaction ends
//   rdata    out  [7:0]  read byte; valid from done until the next gnt
//   nack     out  slave NACK seen in an ACK slot; held until the next gnt
//   busy     out  high from the gnt cycle through the done cycle
//   scl_in   in   SCL pad level
//   sda_in   in   SDA pad level
//   scl_oe   out  1 = pull SCL low
//   sda_oe   out  1 = pull SDA low
// -----------------------------------------------------------------------------
module i2c_txn_sched #(
   parameter int DIVIDER = 3500,
   parameter int CBITS   = 14
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req,
   input  logic [13:0] addr,
   input  logic [1:0]  rw,
   input  logic [15:0] wdata,
   output logic [1:0]  gnt,
   output logic [1:0]  done,
   output logic [7:0]  rdata,
   output logic        nack,
   output logic        busy,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        scl_oe,
   output logic        sda_oe
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_ADDR  = 3'd2;
   localparam logic [2:0] S_AACK  = 3'd3;
   localparam logic [2:0] S_DATA  = 3'd4;
   localparam logic [2:0] S_DACK  = 3'd5;
   localparam logic [2:0] S_STOP  = 3'd6;

   localparam logic [CBITS-1:0] LP_Q1   = CBITS'(DIVIDER);
   localparam logic [CBITS-1:0] LP_Q2   = CBITS'(2 * DIVIDER);
   localparam logic [CBITS-1:0] LP_Q3   = CBITS'(3 * DIVIDER);
   localparam logic [CBITS-1:0] LP_SMP  = CBITS'(3 * DIVIDER - 1);
   localparam logic [CBITS-1:0] LP_LAST = CBITS'(4 * DIVIDER - 1);

   logic [2:0]       r_state;
   logic [CBITS-1:0] r_cnt;
   logic [2:0]       r_bitn;
   logic             r_sel;
   logic             r_last;
   logic [1:0]       r_gnt;
   logic [1:0]       r_done;
   logic             r_nack;
   logic [7:0]       r_rdata;
   logic [7:0]       r_sh;
   logic [7:0]       r_wdata;
   logic             r_rw;

   logic [1:0]       w_phase;
   logic             w_scl_oe;
   logic             w_sda_oe;
   logic             w_hold;
   logic             w_adv;
   logic             w_last;
   logic             w_sample;
   logic             w_grant;
   logic             w_pick;

   // Quarter phase of the current bit
   always_comb begin
      w_phase = 2'd3;
      if (r_cnt < LP_Q1)      w_phase = 2'd0;
      else if (r_cnt < LP_Q2) w_phase = 2'd1;
      else if (r_cnt < LP_Q3) w_phase = 2'd2;
   end

   // Bus drive decode; state and bit shifts only change at phase-0 entry,
   // so SDA moves only while SCL is low (except the START/STOP edges)
   always_comb begin
      w_scl_oe = 1'b0;
      w_sda_oe = 1'b0;
      case (r_state)
         S_START: w_sda_oe = w_phase[1];
         S_ADDR: begin
            w_scl_oe = ~w_phase[1];
            w_sda_oe = ~r_sh[7];
         end
         S_AACK:  w_scl_oe = ~w_phase[1];
         S_DATA: begin
            w_scl_oe = ~w_phase[1];
            w_sda_oe = ~r_rw & ~r_sh[7];
         end
         S_DACK:  w_scl_oe = ~w_phase[1];
         S_STOP: begin
            w_scl_oe = (w_phase == 2'd0);
            w_sda_oe = (w_phase != 2'd3);
         end
         default: begin
            w_scl_oe = 1'b0;
            w_sda_oe = 1'b0;
         end
      endcase
   end

`ifdef I2C_SCHED_STRETCH_EN
   // A slave holding SCL low after release freezes the bit timing
   assign w_hold = w_phase[1] & ~w_scl_oe & ~scl_in;
`else
   // Fixed timing: scl_in is masked off entirely
   assign w_hold = w_phase[1] & ~w_scl_oe & ~scl_in & 1'b0;
`endif

   assign w_adv    = ~w_hold;
   assign w_last   = (r_cnt == LP_LAST) & w_adv;
   assign w_sample = (r_cnt == LP_SMP) & w_adv;

   // No new grant in the done cycle, so a client's stale level request is
   // not re-accepted; it may request again in the following cycle.
   assign w_grant = (r_state == S_IDLE) & ~(|r_done) & (|req);
   // Last-granted client loses a tie
   assign w_pick  = (req == 2'b11) ? ~r_last : req[1];

   // Control: FSM, timing and status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_bitn  <= 3'd0;
         r_sel   <= 1'b0;
         r_last  <= 1'b1;
         r_gnt   <= 2'b00;
         r_done  <= 2'b00;
         r_nack  <= 1'b0;
         r_rdata <= 8'h00;
      end else begin
         r_gnt  <= 2'b00;
         r_done <= 2'b00;
         if (r_state == S_IDLE) begin
            r_cnt <= '0;
            if (w_grant) begin
               r_sel   <= w_pick;
               r_last  <= w_pick;
               r_gnt   <= w_pick ? 2'b10 : 2'b01;
               r_nack  <= 1'b0;
               r_rdata <= 8'h00;
               r_bitn  <= 3'd0;
               r_state <= S_START;
            end
         end else begin
            if (w_adv) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (w_sample) begin
               if ((r_state == S_AACK) || ((r_state == S_DACK) && !r_rw))
                  r_nack <= r_nack | sda_in;
               if ((r_state == S_DATA) && r_rw)
                  r_rdata <= {r_rdata[6:0], sda_in};
            end
            if (w_last) begin
               case (r_state)
                  S_START: begin
                     r_bitn  <= 3'd0;
                     r_state <= S_ADDR;
                  end
                  S_ADDR: begin
                     if (r_bitn == 3'd7) r_state <= S_AACK;
                     else                r_bitn  <= r_bitn + 3'd1;
                  end
                  S_AACK: begin
                     r_bitn  <= 3'd0;
                     r_state <= r_nack ? S_STOP : S_DATA;
                  end
                  S_DATA: begin
                     if (r_bitn == 3'd7) r_state <= S_DACK;
                     else                r_bitn  <= r_bitn + 3'd1;
                  end
                  S_DACK:  r_state <= S_STOP;
                  S_STOP: begin
                     r_done  <= r_sel ? 2'b10 : 2'b01;
                     r_state <= S_IDLE;
                  end
                  default: r_state <= S_IDLE;
               endcase
            end
         end
      end
   end

   // Datapath: outgoing byte shifter, loaded at grant and after the address ACK
   always_ff @(posedge clk) begin
      if (w_grant) begin
         r_sh    <= w_pick ? {addr[13:7], rw[1]} : {addr[6:0], rw[0]};
         r_wdata <= w_pick ? wdata[15:8] : wdata[7:0];
         r_rw    <= w_pick ? rw[1] : rw[0];
      end else if (w_last) begin
         case (r_state)
            S_ADDR:  r_sh <= {r_sh[6:0], 1'b0};
            S_AACK:  r_sh <= r_wdata;
            S_DATA:  r_sh <= {r_sh[6:0], 1'b0};
            default: r_sh <= r_sh;
         endcase
      end
   end

   assign gnt    = r_gnt;
   assign done   = r_done;
   assign rdata  = r_rdata;
   assign nack   = r_nack;
   assign busy   = (r_state != S_IDLE) | (|r_done);
   assign scl_oe = w_scl_oe;
   assign sda_oe = w_sda_oe;

endmodule
